// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out command
// frame and device acknowledge, with start and packet timeouts.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int RTS_CYCLES     = 1000,
   parameter int START_TIMEOUT  = 750000,
   parameter int PACKET_TIMEOUT = 100000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       send,
   input  logic [7:0] cmd,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       error
);

   localparam int MAX_HOST = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int MAX_DEV  = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
   localparam int MAX_CYC  = (MAX_HOST > MAX_DEV) ? MAX_HOST : MAX_DEV;
   localparam int TW       = $clog2(MAX_CYC + 1);

   localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] RTS_LAST     = TW'(RTS_CYCLES - 1);
   localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 1);
   localparam logic [TW-1:0] PACKET_LAST  = TW'(PACKET_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SEND,
      WAIT_ACK,
      WAIT_IDLE
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_inc;
   logic [3:0]    bit_cnt;
   logic [9:0]    frame;
   logic          started;
   logic          clk_s1, clk_s2, clk_prev;
   logic          dat_s1, dat_s2;
   logic          fall;
   logic          timed_out;

   assign fall      = clk_prev & ~clk_s2;
   assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;

   // Before the device's first falling edge only the start window applies;
   // afterwards the whole rest of the packet shares one budget.
   assign timed_out = (state inside {SEND, WAIT_ACK, WAIT_IDLE}) &&
                      (started ? (timer >= PACKET_LAST) : (timer >= START_LAST));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         // NOTE: synchronizers preset to the idle-high bus level so leaving reset
         // never looks like a falling clock edge.
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         clk_prev   <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         state      <= IDLE;
         timer      <= '0;
         bit_cnt    <= '0;
         frame      <= '0;
         started    <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ack_ok     <= 1'b0;
         error      <= 1'b0;
      end else begin
         clk_s1   <= ps2_clk_in;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_dat_in;
         dat_s2   <= dat_s1;
         // NOTE: pulse outputs default low each cycle; only the finishing branch raises them.
         done     <= 1'b0;
         error    <= 1'b0;

         if (timed_out) begin
            // Abort lands directly in IDLE so the error cycle can accept a new send.
            state      <= IDLE;
            busy       <= 1'b0;
            error      <= 1'b1;
            ack_ok     <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (send) begin
                     frame      <= {1'b1, ~^cmd, cmd};
                     ack_ok     <= 1'b0;
                     busy       <= 1'b1;
                     ps2_clk_oe <= 1'b1;
                     ps2_dat_oe <= 1'b0;
                     timer      <= '0;
                     state      <= INHIBIT;
                  end
               end
               INHIBIT: begin
                  if (timer >= INHIBIT_LAST) begin
                     timer      <= '0;
                     ps2_dat_oe <= 1'b1;
                     state      <= RTS;
                  end else begin
                     timer <= timer_inc;
                  end
               end
               RTS: begin
                  if (timer >= RTS_LAST) begin
                     timer      <= '0;
                     bit_cnt    <= '0;
                     started    <= 1'b0;
                     ps2_clk_oe <= 1'b0;
                     state      <= SEND;
                  end else begin
                     timer <= timer_inc;
                  end
               end
               SEND: begin
                  if (fall) begin
                     ps2_dat_oe <= ~frame[bit_cnt];
                     bit_cnt    <= bit_cnt + 4'd1;
                     started    <= 1'b1;
                     timer      <= started ? timer_inc : '0;
                     if (bit_cnt == 4'd9) state <= WAIT_ACK;
                  end else begin
                     timer <= timer_inc;
                  end
               end
               WAIT_ACK: begin
                  timer <= timer_inc;
                  if (fall) begin
                     ack_ok <= ~dat_s2;
                     state  <= WAIT_IDLE;
                  end
               end
               WAIT_IDLE: begin
                  timer <= timer_inc;
                  if (clk_s2 && dat_s2) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a wired-AND bus with a simple PS/2 device
// model clocking at a 40-cycle period and sampling data on its rising edges.
module tb_ps2_host_tx;

   localparam int INHIBIT   = 20;
   localparam int RTS       = 10;
   localparam int START_TO  = 500;
   localparam int PACKET_TO = 2000;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       send = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int overlap_cnt = 0;
   int t_first_fall = 0;
   logic [10:0] cap;

   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT),
      .RTS_CYCLES(RTS),
      .START_TIMEOUT(START_TO),
      .PACKET_TIMEOUT(PACKET_TO)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .send(send),
      .cmd(cmd),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy(busy),
      .done(done),
      .ack_ok(ack_ok),
      .error(error)
   );

   always #10 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (((done || error) && busy) || (done && error)) overlap_cnt++;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_send(input logic [7:0] c);
      cmd  = c;
      send = 1'b1;
      tick();
      send = 1'b0;
   endtask

   task automatic wait_release();
      for (int i = 0; i < 200 && ps2_clk_oe; i++) tick();
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Device: samples start bit before clocking, then one bit per rising edge.
   // The 11th clock is the acknowledge slot, pulled low only when ack is set.
   task automatic dev_frame(input int nclk, input bit ack);
      cap = '0;
      repeat (10) tick();
      cap[0] = ps2_dat_in;
      for (int i = 1; i <= nclk && i <= 11; i++) begin
         if (i == 11 && ack) dev_dat_low = 1'b1;
         if (i == 1) t_first_fall = cyc;
         dev_clk_low = 1'b1;
         repeat (20) tick();
         if (i <= 10) cap[i] = ps2_dat_in;
         dev_clk_low = 1'b0;
         if (i == 11) dev_dat_low = 1'b0;
         else repeat (20) tick();
      end
   endtask

   initial begin
      int cnt;
      int snap_done, snap_err;
      bit seen;

      // Reset state
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check("rst_pulses", {29'd0, done, error, ack_ok}, 32'd0);
      resetn = 1'b1;
      repeat (3) tick();

      // 1: 0xED with ACK
      pulse_send(8'hED);
      check("t1_accept", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'b110);
      cnt = 0;
      while (!ps2_dat_oe && cnt < 100) begin
         cnt++;
         tick();
      end
      check("t1_inhibit_len", 32'(cnt), 32'd20);
      cnt = 0;
      while (ps2_clk_oe && cnt < 100) begin
         cnt++;
         tick();
      end
      check("t1_rts_len", 32'(cnt), 32'd10);
      check("t1_start_held", 32'(ps2_dat_oe), 32'd1);
      dev_frame(11, 1'b1);
      wait_done(seen);
      check("t1_done_seen", 32'(seen), 32'd1);
      check("t1_status", {29'd0, busy, ack_ok, error}, 32'b010);
      check("t1_start_bit", 32'(cap[0]), 32'd0);
      check("t1_byte", 32'(cap[8:1]), 32'hED);
      check("t1_parity_stop", 32'(cap[10:9]), 32'b11);
      tick();
      check("t1_done_one_cycle", 32'(done), 32'd0);
      repeat (5) tick();
      check("t1_ack_hold", 32'(ack_ok), 32'd1);

      // 2: 0xF4 with NACK
      snap_err = err_cnt;
      pulse_send(8'hF4);
      check("t2_ack_cleared", 32'(ack_ok), 32'd0);
      wait_release();
      check("t2_release", 32'(ps2_clk_oe), 32'd0);
      dev_frame(11, 1'b0);
      wait_done(seen);
      check("t2_done_seen", 32'(seen), 32'd1);
      check("t2_byte", 32'(cap[8:1]), 32'hF4);
      check("t2_parity_stop", 32'(cap[10:9]), 32'b10);
      check("t2_ack_error", {30'd0, ack_ok, error}, 32'd0);
      repeat (3) tick();
      check("t2_no_error", 32'(err_cnt - snap_err), 32'd0);

      // 3: device never clocks
      snap_done = done_cnt;
      pulse_send(8'h55);
      wait_release();
      cnt = 0;
      while (!error && cnt < 1000) begin
         tick();
         cnt++;
      end
      check("t3_start_timeout", 32'(cnt), 32'd500);
      check("t3_lines", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      tick();
      check("t3_error_one_cycle", 32'(error), 32'd0);
      repeat (20) tick();
      check("t3_no_done", 32'(done_cnt - snap_done), 32'd0);

      // 4: device stops after 4 clocks, then a full 0xFF exchange
      pulse_send(8'hAA);
      wait_release();
      dev_frame(4, 1'b0);
      cnt = 0;
      while (!error && cnt < 3000) begin
         tick();
         cnt++;
      end
      // 2000-cycle budget plus two synchronizer stages and the edge-detect register
      check("t4_packet_timeout", 32'(cyc - t_first_fall), 32'd2003);
      check("t4_lines", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      repeat (5) tick();
      pulse_send(8'hFF);
      wait_release();
      dev_frame(11, 1'b1);
      wait_done(seen);
      check("t4_done_seen", 32'(seen), 32'd1);
      check("t4_byte", 32'(cap[8:1]), 32'hFF);
      check("t4_parity", 32'(cap[9]), 32'd1);
      check("t4_ack", 32'(ack_ok), 32'd1);
      tick();

      // 5: send while busy is ignored; send in the done cycle restarts
      pulse_send(8'h3C);
      repeat (5) tick();
      pulse_send(8'h00);
      check("t5_busy", 32'(busy), 32'd1);
      wait_release();
      dev_frame(11, 1'b1);
      wait_done(seen);
      check("t5_done_seen", 32'(seen), 32'd1);
      check("t5_byte", 32'(cap[8:1]), 32'h3C);
      check("t5_parity", 32'(cap[9]), 32'd1);
      pulse_send(8'h81);
      check("t5_back_to_back", {28'd0, done, busy, ps2_clk_oe, ps2_dat_oe}, 32'b0110);

      // 6: reset during SEND after data bit 3
      wait_release();
      dev_frame(4, 1'b0);
      check("t6_low_nibble", 32'(cap[4:1]), 32'b0001);
      check("t6_busy_before", {30'd0, busy, ps2_dat_oe}, 32'b11);
      snap_done = done_cnt;
      snap_err = err_cnt;
      @(posedge clock);
      #3;
      resetn = 1'b0;
      #1;
      check("t6_async_release", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      tick();
      resetn = 1'b1;
      repeat (30) tick();
      check("t6_idle", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check("t6_no_pulses", 32'((done_cnt - snap_done) + (err_cnt - snap_err)), 32'd0);

      check("pulse_exclusive", 32'(overlap_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the attached keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), and reports the device acknowledge.
It is the outbound counterpart of the existing PS/2 keyboard receive path. It shares the same PS2_CLK/PS2_DAT pins through open-drain enables that the top level turns into tristate drivers.
While this block is busy, the top level gates the receiver off.

Parameters:
INHIBIT_CYCLES, 6000, clocks that PS2_CLK is held low before request-to-send (120 us at 50 MHz).
RTS_CYCLES, 1000, clocks that PS2_DAT is held low before PS2_CLK is released (20 us).
START_TIMEOUT, 750000, clocks allowed from clock release to the device's first falling edge (15 ms).
PACKET_TIMEOUT, 100000, clocks allowed from the first falling edge to bus idle (2 ms).

Ports:
clock  input  1  system clock (50 MHz)
resetn  input  1  asynchronous, active-low reset
send  input  1  request; one-cycle pulse or level, sampled only in IDLE
cmd  input  8  command byte, latched when send is accepted
ps2_clk_in  input  1  raw PS2_CLK pin level (asynchronous)
ps2_dat_in  input  1  raw PS2_DAT pin level (asynchronous)
ps2_clk_oe  output  1  1 = drive PS2_CLK low; 0 = release
ps2_dat_oe  output  1  1 = drive PS2_DAT low; 0 = release
busy  output  1  transaction in progress
done  output  1  one-cycle pulse: transaction finished normally
ack_ok  output  1  valid with done; 1 = device ACKed (data low at 11th falling edge)
error  output  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (asynchronous, resetn=0):
  - all outputs go to 0, state goes to IDLE, counters clear, synchronizers preset to 1.
  - a reset mid-transaction releases both lines immediately.
- Inputs: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer.
- Falling edge (fall): previous synced clk = 1 and current synced clk = 0.
- Parity: odd, par = ~^cmd. The shift frame is {1'b1 stop, par, cmd[7:0]}, sent LSB first.
- States:
  - IDLE:
    - busy=0, both oe=0.
    - send=1 latches cmd → INHIBIT; busy=1 from the next cycle.
  - INHIBIT:
    - clk_oe=1, dat_oe=0.
    - after INHIBIT_CYCLES clocks → RTS.
  - RTS:
    - clk_oe=1, dat_oe=1 (start bit).
    - after RTS_CYCLES → SEND; clear bit_cnt and the timer.
  - SEND:
    - clk_oe=0. dat_oe holds the start bit (1) until the first fall.
    - On each fall: dat_oe = ~frame[bit_cnt], then bit_cnt++.
    - Falls 1-8 send data bits 0-7, fall 9 sends parity, fall 10 releases data (stop; dat_oe=0).
    - After fall 10 → WAIT_ACK.
    - Before the first fall, timer ≥ START_TIMEOUT → ABORT.
    - After the first fall, the timer restarts and is checked against PACKET_TIMEOUT through WAIT_IDLE.
  - WAIT_ACK:
    - both oe=0.
    - On the 11th fall, ack_ok ← ~synced dat → WAIT_IDLE.
  - WAIT_IDLE:
    - both oe=0.
    - When synced clk=1 and synced dat=1 → IDLE with done=1 for one cycle.
  - ABORT:
    - both oe=0, error=1 for one cycle, ack_ok=0 → IDLE.
- done and error never assert together. Both assert only in a cycle where busy=0.
- send is accepted in the same cycle that done or error pulses (state is IDLE).
- send while busy is ignored; it is not queued.
- Falls during INHIBIT or RTS are ignored (the host is driving the clock).
- ack_ok holds its value until the next accepted send, which clears it.
- The timer is sized by $clog2 of the largest parameter + 1 and saturates; it never wraps.

Test Plan:
- Bench overrides: INHIBIT=20, RTS=10, START_TIMEOUT=500, PACKET_TIMEOUT=2000.
- Device model: clocks at a 40-cycle period and samples data on rising edges.

1. Send cmd=0xED, device ACKs → clk_oe high for 20 cycles, then dat_oe rises. Model captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. done=1, ack_ok=1, busy falls with done.
2. Send cmd=0xF4, device releases data at the 11th bit (NACK) → captured bits 0,0,1,0,1,1,1,1, parity 0. done=1, ack_ok=0, error=0.
3. Send, device never clocks → exactly 500 cycles after clock release: error=1 for one cycle, both oe=0, done never asserts.
4. Device stops after 4 clocks → error pulse once PACKET_TIMEOUT (2000) elapses from the first fall; lines released; a following send of 0xFF completes with ack_ok=1.
5. Assert send again 5 cycles after acceptance with cmd=0x00 → ignored; transmitted byte remains the first cmd. Send pulsed in the done cycle → new INHIBIT starts next cycle.
6. resetn=0 during SEND after bit 3 → clk_oe=dat_oe=busy=0 asynchronously. After release, IDLE; no done or error pulse appears.
